// File: rtl/eth_pio_pkg.sv
// Shared constants for the Ethernet-system PIO controller: register map,
// bus width and the debounce counter sizing helper.
package eth_pio_pkg;

    localparam int BUS_W = 32;

    localparam logic [2:0] ADDR_DATA_IN      = 3'd0;
    localparam logic [2:0] ADDR_DATA_OUT     = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK     = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP     = 3'd3;
    localparam logic [2:0] ADDR_EDGE_SEL     = 3'd4;
    localparam logic [2:0] ADDR_BLINK_EN     = 3'd5;
    localparam logic [2:0] ADDR_BLINK_PERIOD = 3'd6;
    localparam logic [2:0] ADDR_TIMESTAMP    = 3'd7;

    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/eth_pio_debounce.sv
// One input bit: 2-flop synchroniser followed by a stability counter.
// flip pulses on the cycle the debounced value is about to change.
module eth_pio_debounce
    import eth_pio_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 500000,
    parameter logic IDLE            = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout,
    output logic flip
);

    localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             db_r;
    logic [CNT_W-1:0] cnt_r;
    logic             flip_s;

    assign flip_s = (sync2_r != db_r) && (cnt_r == CNT_LAST);
    assign dout   = db_r;
    assign flip   = flip_s;

    // Synchroniser, stability counter and debounced state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= IDLE;
            sync2_r <= IDLE;
            db_r    <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            sync1_r <= din;
            sync2_r <= sync1_r;
            if (sync2_r == db_r) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (flip_s) begin
                db_r  <= sync2_r;
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/eth_pio_ctrl.sv
// Avalon-MM PIO controller: debounced inputs with edge capture and masked IRQ,
// outputs with hardware blink. Define PIO_TIMESTAMP_EN for the edge timestamp.
module eth_pio_ctrl
    import eth_pio_pkg::*;
#(
    parameter int                  IN_WIDTH        = 3,
    parameter int                  OUT_WIDTH       = 8,
    parameter int                  DEBOUNCE_CYCLES = 500000,
    parameter logic [IN_WIDTH-1:0] IN_IDLE         = {IN_WIDTH{1'b1}},
    parameter int                  BLINK_W         = 24
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [2:0]           avs_address,
    input  logic                 avs_read,
    input  logic                 avs_write,
    input  logic [BUS_W-1:0]     avs_writedata,
    output logic [BUS_W-1:0]     avs_readdata,
    output logic                 irq,
    input  logic [IN_WIDTH-1:0]  pio_in,
    output logic [OUT_WIDTH-1:0] pio_out
);

    logic [IN_WIDTH-1:0]  db_s;
    logic [IN_WIDTH-1:0]  flip_s;
    logic [IN_WIDTH-1:0]  hit_s;
    logic [IN_WIDTH-1:0]  clr_s;
    logic [IN_WIDTH-1:0]  cap_next_s;
    logic [BUS_W-1:0]     rdata_s;
    logic [BUS_W-1:0]     ts_s;
    logic                 unused_s;

    logic [OUT_WIDTH-1:0] data_out_r;
    logic [IN_WIDTH-1:0]  irq_mask_r;
    logic [IN_WIDTH-1:0]  edge_cap_r;
    logic [IN_WIDTH-1:0]  edge_sel_r;
    logic [OUT_WIDTH-1:0] blink_en_r;
    logic [BLINK_W-1:0]   blink_period_r;
    logic [BLINK_W-1:0]   blink_cnt_r;
    logic                 phase_r;
    logic [BUS_W-1:0]     readdata_r;
    logic                 irq_r;
    logic [OUT_WIDTH-1:0] pio_out_r;

    assign unused_s     = ^avs_writedata;
    assign avs_readdata = readdata_r;
    assign irq          = irq_r;
    assign pio_out      = pio_out_r;

    for (genvar i = 0; i < IN_WIDTH; i++) begin : g_bit
        eth_pio_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .IDLE            (IN_IDLE[i])
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .din     (pio_in[i]),
            .dout    (db_s[i]),
            .flip    (flip_s[i])
        );
    end

    // Edge detection is taken from the flip pulse so capture lands with the debounced update.
    always_comb begin
        hit_s = (flip_s & ~db_s & edge_sel_r) | (flip_s & db_s & ~edge_sel_r);
        if (avs_write && (avs_address == ADDR_EDGE_CAP)) begin
            clr_s = avs_writedata[IN_WIDTH-1:0];
        end else begin
            clr_s = {IN_WIDTH{1'b0}};
        end
        cap_next_s = (edge_cap_r & ~clr_s) | hit_s;
    end

    // Read mux over the pre-write register state.
    always_comb begin
        rdata_s = {BUS_W{1'b0}};
        case (avs_address)
            ADDR_DATA_IN:      rdata_s[IN_WIDTH-1:0]  = db_s;
            ADDR_DATA_OUT:     rdata_s[OUT_WIDTH-1:0] = data_out_r;
            ADDR_IRQ_MASK:     rdata_s[IN_WIDTH-1:0]  = irq_mask_r;
            ADDR_EDGE_CAP:     rdata_s[IN_WIDTH-1:0]  = edge_cap_r;
            ADDR_EDGE_SEL:     rdata_s[IN_WIDTH-1:0]  = edge_sel_r;
            ADDR_BLINK_EN:     rdata_s[OUT_WIDTH-1:0] = blink_en_r;
            ADDR_BLINK_PERIOD: rdata_s[BLINK_W-1:0]   = blink_period_r;
            ADDR_TIMESTAMP:    rdata_s                = ts_s;
            default:           rdata_s                = {BUS_W{1'b0}};
        endcase
    end

    // Control registers, capture, interrupt and bus/output pipeline.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_r     <= {OUT_WIDTH{1'b0}};
            irq_mask_r     <= {IN_WIDTH{1'b0}};
            edge_cap_r     <= {IN_WIDTH{1'b0}};
            edge_sel_r     <= {IN_WIDTH{1'b0}};
            blink_en_r     <= {OUT_WIDTH{1'b0}};
            blink_period_r <= {BLINK_W{1'b0}};
            readdata_r     <= {BUS_W{1'b0}};
            irq_r          <= 1'b0;
            pio_out_r      <= {OUT_WIDTH{1'b0}};
        end else begin
            if (avs_write) begin
                case (avs_address)
                    ADDR_DATA_OUT:     data_out_r     <= avs_writedata[OUT_WIDTH-1:0];
                    ADDR_IRQ_MASK:     irq_mask_r     <= avs_writedata[IN_WIDTH-1:0];
                    ADDR_EDGE_SEL:     edge_sel_r     <= avs_writedata[IN_WIDTH-1:0];
                    ADDR_BLINK_EN:     blink_en_r     <= avs_writedata[OUT_WIDTH-1:0];
                    ADDR_BLINK_PERIOD: blink_period_r <= avs_writedata[BLINK_W-1:0];
                    default:           ;
                endcase
            end
            edge_cap_r <= cap_next_s;
            irq_r      <= |(edge_cap_r & irq_mask_r);
            readdata_r <= avs_read ? rdata_s : {BUS_W{1'b0}};
            pio_out_r  <= data_out_r ^ (blink_en_r & {OUT_WIDTH{phase_r}});
        end
    end

    // Shared blink timebase; a zero period parks it, a period write restarts it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt_r <= {BLINK_W{1'b0}};
            phase_r     <= 1'b0;
        end else if (avs_write && (avs_address == ADDR_BLINK_PERIOD)) begin
            blink_cnt_r <= {BLINK_W{1'b0}};
            phase_r     <= 1'b0;
        end else if (blink_period_r == {BLINK_W{1'b0}}) begin
            blink_cnt_r <= {BLINK_W{1'b0}};
            phase_r     <= 1'b0;
        end else if (blink_cnt_r == blink_period_r) begin
            blink_cnt_r <= {BLINK_W{1'b0}};
            phase_r     <= ~phase_r;
        end else begin
            blink_cnt_r <= blink_cnt_r + {{(BLINK_W-1){1'b0}}, 1'b1};
        end
    end

`ifdef PIO_TIMESTAMP_EN
    logic [BUS_W-1:0] ts_cnt_r;
    logic [BUS_W-1:0] ts_r;

    // Free-running cycle count, sampled when capture goes from empty to non-empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_cnt_r <= {BUS_W{1'b0}};
            ts_r     <= {BUS_W{1'b0}};
        end else begin
            ts_cnt_r <= ts_cnt_r + 32'd1;
            if ((edge_cap_r == {IN_WIDTH{1'b0}}) && (cap_next_s != {IN_WIDTH{1'b0}})) begin
                ts_r <= ts_cnt_r;
            end
        end
    end

    assign ts_s = ts_r;
`else
    assign ts_s = {BUS_W{1'b0}};
`endif

endmodule
